// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32 core.
// Keeps at most one instruction-memory request in flight and tracks stale responses after redirects.
module fetch_stage #(
    parameter int               Width   = 32,
    parameter logic [Width-1:0] ResetPC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [Width-1:0] PCTargetE,
    output logic             imem_req,
    output logic [Width-1:0] imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [Width-1:0] PCF,
    output logic [31:0]      InstrD,
    output logic [Width-1:0] PCD,
    output logic [Width-1:0] PCPlus4D,
    output logic             InstrValidD
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam logic [31:0]      NopInstr = 32'h0000_0013;
    localparam logic [Width-1:0] Four     = Width'(4);

    state_e           state_q, state_d;
    logic             kill_q, kill_d;
    logic [31:0]      instr_buf_q, instr_buf_d;
    logic [Width-1:0] pcf_q, pcf_d;
    logic [31:0]      instr_q, instr_d;
    logic [Width-1:0] pcd_q, pcd_d;
    logic [Width-1:0] pc_plus4_q, pc_plus4_d;
    logic             valid_q, valid_d;

    logic             resp_avail;
    logic             accept;
    logic [31:0]      resp_instr;
    logic [Width-1:0] pcf_plus4;

    assign pcf_plus4  = pcf_q + Four;
    assign resp_avail = (state_q == S_WAIT && imem_rvalid && !kill_q) || (state_q == S_HOLD);
    assign accept     = resp_avail && !StallD && !PCSrcE;
    assign resp_instr = (state_q == S_HOLD) ? instr_buf_q : imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            kill_q      <= 1'b0;
            instr_buf_q <= '0;
            pcf_q       <= ResetPC;
            instr_q     <= NopInstr;
            pcd_q       <= '0;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            instr_buf_q <= instr_buf_d;
            pcf_q       <= pcf_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
        end
    end

    // A redirect while a request is in flight cannot cancel it, so the response is marked stale instead.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        instr_buf_d = instr_buf_q;
        pcf_d       = pcf_q;
        if (PCSrcE) begin
            pcf_d = PCTargetE;
            if (state_q == S_WAIT && !imem_rvalid) begin
                kill_d = 1'b1;
            end else begin
                state_d = S_FETCH;
                kill_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_FETCH;
                        end else if (StallD) begin
                            instr_buf_d = imem_rdata;
                            state_d     = S_HOLD;
                        end else begin
                            pcf_d = pcf_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        pcf_d   = pcf_plus4;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        instr_d    = instr_q;
        pcd_d      = pcd_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (FlushD || PCSrcE || (!accept && !StallD)) begin
            instr_d    = NopInstr;
            pcd_d      = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (accept) begin
            instr_d    = resp_instr;
            pcd_d      = pcf_q;
            pc_plus4_d = pcf_plus4;
            valid_d    = 1'b1;
        end
    end

    // Accepting a response immediately issues the next sequential request in the same cycle.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pcf_q;
        if (!reset && !PCSrcE) begin
            if (state_q == S_FETCH) begin
                imem_req = 1'b1;
            end else if (accept) begin
                imem_req  = 1'b1;
                imem_addr = pcf_plus4;
            end
        end
    end

    assign PCF         = pcf_q;
    assign InstrD      = instr_q;
    assign PCD         = pcd_q;
    assign PCPlus4D    = pc_plus4_q;
    assign InstrValidD = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency instruction memory returning 0x1000_0000 + address.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_rvalid, InstrValidD;
    logic [31:0] imem_addr, imem_rdata, PCF, InstrD, PCD, PCPlus4D;

    int total = 0;
    int bad   = 0;
    int lat   = 1;

    logic [7:0]  vpipe = '0;
    logic [31:0] apipe [8];

    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam logic [31:0] Tag = 32'h1000_0000;

    always #5 clk = ~clk;

    fetch_stage #(.Width(32), .ResetPC(32'h0)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD)
    );

    // Memory answers each request exactly lat cycles later, whatever state the fetch stage is in.
    always @(posedge clk) begin
        vpipe    <= {vpipe[6:0], imem_req};
        apipe[0] <= imem_addr;
        for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
    end
    assign imem_rvalid = vpipe[lat-1];
    assign imem_rdata  = Tag + apipe[lat-1];

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic stall, input logic flush,
                                 input logic pcsrc, input logic [31:0] target);
        reset     = rst;
        StallD    = stall;
        FlushD    = flush;
        PCSrcE    = pcsrc;
        PCTargetE = target;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, " instr"}, InstrD, Nop);
        checkOutput({tag, " valid"}, {31'd0, InstrValidD}, 32'd0);
        checkOutput({tag, " pcd"}, PCD, 32'd0);
        checkOutput({tag, " pcplus4"}, PCPlus4D, 32'd0);
    endtask

    task automatic checkInstr(input string tag, input logic [31:0] pc);
        checkOutput({tag, " instr"}, InstrD, Tag + pc);
        checkOutput({tag, " valid"}, {31'd0, InstrValidD}, 32'd1);
        checkOutput({tag, " pcd"}, PCD, pc);
        checkOutput({tag, " pcplus4"}, PCPlus4D, pc + 32'd4);
    endtask

    task automatic checkReq(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, " req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) checkOutput({tag, " addr"}, imem_addr, addr);
    endtask

    initial begin
        // Reset with single-cycle memory
        lat = 1;
        applyStimulus(1, 0, 0, 0, 32'h0);
        repeat (3) begin
            nextCycle();
            applyStimulus(1, 0, 0, 0, 32'h0);
        end
        checkReq("rst", 0, 32'h0);
        checkBubble("rst");
        checkOutput("rst pcf", PCF, 32'h0);

        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("c0", 1, 32'h0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("c1", 1, 32'h4);
        checkBubble("c1");
        for (int n = 2; n <= 5; n++) begin
            nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
            checkInstr("stream", 32'(4 * (n - 2)));
            checkReq("stream", 1, 32'(4 * n));
        end

        // Stall for two cycles while the response for 0x14 arrives
        nextCycle(); applyStimulus(0, 1, 0, 0, 32'h0);
        checkInstr("stall0", 32'h10);
        checkReq("stall0", 0, 32'h0);
        nextCycle(); applyStimulus(0, 1, 0, 0, 32'h0);
        checkInstr("stall1", 32'h10);
        checkReq("stall1", 0, 32'h0);
        checkOutput("stall1 pcf", PCF, 32'h14);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkInstr("release", 32'h10);
        checkReq("release", 1, 32'h18);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkInstr("buffered", 32'h14);
        checkReq("buffered", 1, 32'h1C);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkInstr("after buf", 32'h18);

        // Redirect in the same cycle as a response
        nextCycle(); applyStimulus(0, 0, 0, 1, 32'h200);
        checkInstr("redir rv", 32'h1C);
        checkOutput("redir rv rvalid", {31'd0, imem_rvalid}, 32'd1);
        checkReq("redir rv", 0, 32'h0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("redir bub");
        checkReq("redir tgt", 1, 32'h200);
        checkOutput("redir pcf", PCF, 32'h200);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("redir bub2");
        checkReq("redir next", 1, 32'h204);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkInstr("redir instr", 32'h200);

        // Reset long enough for the memory pipe to drain, then switch to 3-cycle memory
        nextCycle(); applyStimulus(1, 0, 0, 0, 32'h0);
        lat = 3;
        repeat (10) begin
            nextCycle(); applyStimulus(1, 0, 0, 0, 32'h0);
        end
        checkBubble("rst2");
        checkReq("rst2", 0, 32'h0);

        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("s3 c0", 1, 32'h0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("s3 c1", 0, 32'h0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("s3 c2", 0, 32'h0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("s3 c3", 1, 32'h4);
        checkBubble("s3 c3");
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkInstr("s3 c4", 32'h0);
        checkReq("s3 c4", 0, 32'h0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("s3 c5");
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("s3 c6");
        checkReq("s3 c6", 1, 32'h8);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkInstr("s3 c7", 32'h4);

        // Redirect to 0x100 while the request to 0x8 is still outstanding
        nextCycle(); applyStimulus(0, 0, 0, 1, 32'h100);
        checkBubble("kill c8");
        checkReq("kill c8", 0, 32'h0);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("kill stale rvalid", {31'd0, imem_rvalid}, 32'd1);
        checkReq("kill c9", 0, 32'h0);
        checkOutput("kill pcf", PCF, 32'h100);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("kill c10");
        checkReq("kill c10", 1, 32'h100);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("kill c11");
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("kill c12");
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("kill c13", 1, 32'h104);
        nextCycle(); applyStimulus(0, 1, 1, 0, 32'h0);
        checkInstr("kill c14", 32'h100);

        // Flush wins over stall
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkBubble("flush");
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("flush c16", 1, 32'h108);
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkInstr("flush c17", 32'h104);

        // Reset while waiting on 0x108; its response lands during reset
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkReq("midrst", 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            nextCycle(); applyStimulus(1, 0, 0, 0, 32'h0);
            checkBubble("midrst hold");
            checkReq("midrst hold", 0, 32'h0);
            checkOutput("midrst pcf", PCF, 32'h0);
        end
        nextCycle(); applyStimulus(0, 0, 0, 0, 32'h0);
        checkReq("post rst", 1, 32'h0);
        checkBubble("post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32 core. Owns PCF, issues requests to a variable-latency instruction memory (at most one outstanding), and delivers InstrD/PCD/PCPlus4D to the decode stage, where InstrD[6:0], InstrD[14:12] and InstrD[30] drive the controller's opcode/funct3/funct7_5. Handles hazard-unit stall/flush and EX-stage branch/jump redirects, including redirects that arrive while a fetch is in flight.

## Interface
- Width, 32, datapath/address width
- ResetPC, 32'h0000_0000, PCF value after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- StallD  in  1  hazard unit: hold IF/ID contents
- FlushD  in  1  hazard unit: load bubble into IF/ID
- PCSrcE  in  1  EX redirect (taken beq or jal)
- PCTargetE  in  Width  redirect target
- imem_req  out  1  request strobe; always accepted by memory
- imem_addr  out  Width  request address (word aligned)
- imem_rvalid  in  1  response valid, ≥1 cycle after its request
- imem_rdata  in  32  response instruction
- PCF  out  Width  current fetch PC
- InstrD  out  32  decode instruction
- PCD  out  Width  PC of InstrD
- PCPlus4D  out  Width  PCD + 4
- InstrValidD  out  1  InstrD is a real fetched instruction (0 = bubble)

## Operation
- Bubble = InstrD 32'h0000_0013 (addi x0,x0,0), PCD=0, PCPlus4D=0, InstrValidD=0.
- State: FETCH (must issue request), WAIT (one request outstanding), HOLD (response buffered, decode stalled); flag kill (outstanding response is stale); buffer InstrBuf.
- imem_req is combinational and 0 whenever reset or PCSrcE is high; no request is ever issued in a redirect cycle.
- accept = response available (WAIT & imem_rvalid & !kill, or HOLD) & !StallD & !PCSrcE.
- FETCH: imem_req=1, imem_addr=PCF → WAIT.
- WAIT, imem_rvalid, !kill, accept: IF/ID ← {imem_rdata, PCF, PCF+4}; PCF ← PCF+4; same cycle imem_req=1, imem_addr=PCF+4; stay WAIT.
- WAIT, imem_rvalid, !kill, StallD, !PCSrcE: InstrBuf ← imem_rdata → HOLD.
- WAIT, !imem_rvalid: stay; imem_req=0.
- HOLD, accept: IF/ID ← {InstrBuf, PCF, PCF+4}; PCF ← PCF+4; issue imem_addr=PCF+4 → WAIT. HOLD with StallD: stay, buffer kept.
- PCSrcE (priority over all above): PCF ← PCTargetE; IF/ID ← bubble. WAIT without rvalid: kill ← 1, stay WAIT. WAIT with rvalid (response discarded), HOLD (buffer discarded), FETCH → FETCH, kill ← 0.
- WAIT, kill, imem_rvalid: response discarded, kill ← 0 → FETCH. PCSrcE again while kill set: PCF updated, kill stays 1.
- IF/ID priority: FlushD or PCSrcE → bubble; else accept → new instruction; else !StallD → bubble; else hold.
- PCF+4 and PCPlus4D wrap modulo 2^Width; PCF[1:0] is never interpreted.

## Timing
- Reset: PCF=ResetPC, state FETCH, kill=0, InstrBuf=0, IF/ID = bubble, imem_req=0 while reset high.
- First cycle after reset deassert: imem_req=1, imem_addr=ResetPC.
- 1-cycle memory: first instruction on InstrD 2 cycles after first request; steady state one instruction per cycle.
- N-cycle memory: one instruction per N cycles; bubbles (InstrValidD=0) fill gaps.
- Redirect penalty: first request to PCTargetE in cycle after PCSrcE (or after stale response returns if killed).
- StallD for k cycles holds InstrD/PCD/PCPlus4D/InstrValidD unchanged for k cycles; no instruction lost or duplicated.

## Test plan
- Reset then 1-cycle memory returning addr-tagged words: requests 0x0,0x4,0x8… on consecutive cycles; InstrD sequence matches from cycle 2, InstrValidD=1 continuously.
- 3-cycle memory: one request per 3 cycles; two bubbles (InstrD=0x00000013, InstrValidD=0) between valid instructions.
- StallD high 2 cycles while response arrives: state HOLD, IF/ID unchanged; on release buffered word appears once with correct PCD, next request PCF+4.
- PCSrcE with PCTargetE=0x100 while request to 0x8 outstanding (3-cycle memory): stale 0x8 word dropped, never on InstrD; next request 0x100; InstrD shows bubble then 0x100 instruction.
- PCSrcE in same cycle as imem_rvalid: response dropped, imem_req=0 that cycle, request to target next cycle.
- FlushD with StallD high: IF/ID becomes bubble; reset asserted mid-WAIT: all outputs return to reset values, late rvalid ignored.
